// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter.
// Holds widths, the step-counter width and the FSM state encoding.
package bcd_pkg;

    localparam int unsigned BIN_W      = 16;
    localparam int unsigned NUM_DIGITS = 5;
    localparam int unsigned BCD_W      = 20;
    localparam int unsigned CNT_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CONV   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD nibble that is 5 or more,
// so that the following left shift carries correctly into the next digit.
// Ports:
//   i_digit : BCD nibble before correction
//   o_digit : corrected nibble
module bcd_digit_adj (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);

    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin16_to_bcd_seq.sv
// Sequential double-dabble converter: 16-bit two's-complement value in,
// sign flag plus five BCD digits out. One shift/add-3 step per clock.
// Outputs are registered and only change on the COMMIT edge.
// Ports:
//   clk        : system clock, rising edge
//   KEY        : asynchronous active-low reset
//   bin_in     : two's-complement value to convert
//   start      : conversion request, honoured in IDLE only
//   busy       : conversion in flight (decoded from state flops)
//   done       : one-cycle pulse with the first cycle of new outputs
//   negative   : sign of the converted value
//   bcd_digit0 : ones ... bcd_digit4 : ten-thousands
module bin16_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter bit AUTO_START = 1'b1
) (
    input  logic             clk,
    input  logic             KEY,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             negative,
    output logic [3:0]       bcd_digit0,
    output logic [3:0]       bcd_digit1,
    output logic [3:0]       bcd_digit2,
    output logic [3:0]       bcd_digit3,
    output logic [3:0]       bcd_digit4
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic                     r_sign;
    logic [BIN_W-1:0]         r_mag;
    logic [BIN_W-1:0]         r_last;
    logic [BCD_W-1:0]         r_acc;
    logic [BCD_W-1:0]         w_acc_adj;
    logic [BCD_W+BIN_W-1:0]   w_shift;
    logic [BCD_W-1:0]         r_digits;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_done;
    logic                     r_negative;
    logic                     w_req;

    // Last-value compare lets AUTO mode pick up any update missed while busy.
    assign w_req = start | (AUTO_START & (bin_in != r_last));

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .i_digit (r_acc[4*g +: 4]),
            .o_digit (w_acc_adj[4*g +: 4])
        );
    end

    assign w_shift = {w_acc_adj, r_mag} << 1;

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (w_req) w_state_next = ST_CONV;
            ST_CONV:   if (r_cnt == '1) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge KEY) begin
        if (!KEY) begin
            r_sign     <= 1'b0;
            r_mag      <= '0;
            r_last     <= '0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_digits   <= '0;
            r_negative <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_req) begin
                        r_sign <= bin_in[BIN_W-1];
                        // 0x8000 negates to itself, which reads as 32768 unsigned.
                        r_mag  <= bin_in[BIN_W-1] ? (~bin_in + BIN_W'(1)) : bin_in;
                        r_last <= bin_in;
                        r_acc  <= '0;
                        r_cnt  <= '0;
                    end
                end
                ST_CONV: begin
                    r_acc <= w_shift[BCD_W+BIN_W-1:BIN_W];
                    r_mag <= w_shift[BIN_W-1:0];
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                ST_COMMIT: begin
                    r_digits   <= r_acc;
                    r_negative <= r_sign;
                    r_done     <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy       = (r_state != ST_IDLE);
    assign done       = r_done;
    assign negative   = r_negative;
    assign bcd_digit0 = r_digits[3:0];
    assign bcd_digit1 = r_digits[7:4];
    assign bcd_digit2 = r_digits[11:8];
    assign bcd_digit3 = r_digits[15:12];
    assign bcd_digit4 = r_digits[19:16];

endmodule

// File: tb/tb_bin16_to_bcd_seq.sv
// Bench for bin16_to_bcd_seq: one manual-start instance and one AUTO_START
// instance, checked every cycle against a cycle-count/decimal-arithmetic model.
module tb_bin16_to_bcd_seq;

    logic        clk;
    logic        KEY;
    logic [15:0] bin_m, bin_a;
    logic        start_m, start_a;
    logic        busy_m, done_m, neg_m, busy_a, done_a, neg_a;
    logic [3:0]  dm0, dm1, dm2, dm3, dm4, da0, da1, da2, da3, da4;
    logic [19:0] dig_m, dig_a;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 0;

    assign dig_m = {dm4, dm3, dm2, dm1, dm0};
    assign dig_a = {da4, da3, da2, da1, da0};

    bin16_to_bcd_seq #(.AUTO_START(1'b0)) u_dut_m (
        .clk(clk), .KEY(KEY), .bin_in(bin_m), .start(start_m),
        .busy(busy_m), .done(done_m), .negative(neg_m),
        .bcd_digit0(dm0), .bcd_digit1(dm1), .bcd_digit2(dm2),
        .bcd_digit3(dm3), .bcd_digit4(dm4)
    );

    bin16_to_bcd_seq #(.AUTO_START(1'b1)) u_dut_a (
        .clk(clk), .KEY(KEY), .bin_in(bin_a), .start(start_a),
        .busy(busy_a), .done(done_a), .negative(neg_a),
        .bcd_digit0(da0), .bcd_digit1(da1), .bcd_digit2(da2),
        .bcd_digit3(da3), .bcd_digit4(da4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int          m_cnt  [2];   // cycles of busy remaining, 0 = idle
    logic [15:0] m_val  [2];
    logic [15:0] m_last [2];
    logic        m_done [2];
    logic        m_neg  [2];
    logic [19:0] m_dig  [2];

    function automatic logic [19:0] to_bcd(input int n);
        logic [19:0] r;
        int x;
        x = n;
        r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_val[i] = '0; m_last[i] = '0;
            m_done[i] = 0; m_neg[i] = 0; m_dig[i] = '0;
        end
    endtask

    task automatic model_step(input int i, input logic [15:0] b, input logic st, input bit auto);
        int v;
        m_done[i] = 0;
        if (m_cnt[i] == 0) begin
            if (st || (auto && b != m_last[i])) begin
                m_val[i]  = b;
                m_last[i] = b;
                m_cnt[i]  = 17;  // 16 conversion steps plus the commit cycle
            end
        end else begin
            m_cnt[i] = m_cnt[i] - 1;
            if (m_cnt[i] == 0) begin
                v = int'($signed(m_val[i]));
                m_neg[i]  = (v < 0);
                m_dig[i]  = to_bcd(v < 0 ? -v : v);
                m_done[i] = 1;
            end
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge KEY);
            if (!KEY) model_reset();
            else begin
                model_step(0, bin_m, start_m, 1'b0);
                model_step(1, bin_a, start_a, 1'b1);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("m.busy", int'(busy_m), int'(m_cnt[0] != 0));
                chk("m.done", int'(done_m), int'(m_done[0]));
                chk("m.neg",  int'(neg_m),  int'(m_neg[0]));
                chk("m.dig",  int'(dig_m),  int'(m_dig[0]));
                chk("a.busy", int'(busy_a), int'(m_cnt[1] != 0));
                chk("a.done", int'(done_a), int'(m_done[1]));
                chk("a.neg",  int'(neg_a),  int'(m_neg[1]));
                chk("a.dig",  int'(dig_a),  int'(m_dig[1]));
            end
        end
    end

    task automatic check_all_zero(input string name);
        chk({name, ".busy_m"}, int'(busy_m), 0);
        chk({name, ".done_m"}, int'(done_m), 0);
        chk({name, ".neg_m"},  int'(neg_m),  0);
        chk({name, ".dig_m"},  int'(dig_m),  0);
        chk({name, ".busy_a"}, int'(busy_a), 0);
        chk({name, ".done_a"}, int'(done_a), 0);
        chk({name, ".neg_a"},  int'(neg_a),  0);
        chk({name, ".dig_a"},  int'(dig_a),  0);
    endtask

    // Start a manual conversion and pin the result against literals.
    task automatic run_manual(input string name, input logic [15:0] v,
                              input logic [19:0] exp_dig, input logic exp_neg);
        int bc;
        bit got;
        bc = 0;
        got = 0;
        @(negedge clk);
        bin_m = v;
        start_m = 1'b1;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            #1;
            start_m = 1'b0;
            if (busy_m) bc++;
            if (done_m) got = 1;
        end
        chk({name, ".done_seen"}, int'(got), 1);
        chk({name, ".busy_cycles"}, bc, 17);
        chk({name, ".digits"}, int'(dig_m), int'(exp_dig));
        chk({name, ".negative"}, int'(neg_m), int'(exp_neg));
    endtask

    task automatic wait_done_a(input string name, input logic [19:0] exp_dig);
        bit got;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            #1;
            if (n == 0) chk({name, ".accept_next_edge"}, int'(busy_a), 1);
            if (done_a) got = 1;
        end
        chk({name, ".done_seen"}, int'(got), 1);
        chk({name, ".digits"}, int'(dig_a), int'(exp_dig));
        chk({name, ".negative"}, int'(neg_a), 0);
    endtask

    logic [15:0] corners [6] = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h8001};

    initial begin
        int cnt;
        logic [19:0] seen_dig;
        KEY = 1'b1;
        bin_m = '0; bin_a = '0;
        start_m = 1'b0; start_a = 1'b0;
        #1 KEY = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_all_zero("reset");
        cmp_en = 1;
        @(posedge clk);
        #3 KEY = 1'b1;

        // AUTO with zero input after reset: nothing to convert.
        cnt = 0;
        repeat (6) begin @(negedge clk); #1; if (done_a || busy_a) cnt++; end
        chk("auto.zero_idle", cnt, 0);

        run_manual("p12345", 16'd12345, 20'h12345, 1'b0);
        run_manual("m1",     16'hFFFF,  20'h00001, 1'b1);
        run_manual("m32768", 16'h8000,  20'h32768, 1'b1);
        run_manual("p32767", 16'd32767, 20'h32767, 1'b0);
        run_manual("zero",   16'd0,     20'h00000, 1'b0);

        // Retrigger and input change mid-conversion are ignored.
        @(negedge clk);
        bin_m = 16'd12345;
        start_m = 1'b1;
        cnt = 0;
        seen_dig = '0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            #1;
            if (n == 1) start_m = 1'b0;
            if (n == 5) begin start_m = 1'b1; bin_m = 16'd999; end
            if (n == 6) start_m = 1'b0;
            if (done_m) begin cnt++; seen_dig = dig_m; end
        end
        chk("midconv.done_count", cnt, 1);
        chk("midconv.digits", int'(seen_dig), int'(20'h12345));

        // AUTO mode follows input changes without start.
        @(negedge clk);
        bin_a = 16'd100;
        wait_done_a("auto100", 20'h00100);
        @(negedge clk);
        bin_a = 16'd250;
        wait_done_a("auto250", 20'h00250);
        cnt = 0;
        repeat (40) begin @(negedge clk); #1; if (done_a) cnt++; end
        chk("auto.held_no_done", cnt, 0);

        // Randomized traffic on both instances, checked by the model.
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) bin_m = corners[$urandom_range(0, 5)];
            else bin_m = 16'($urandom);
            start_m = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 24) == 0) begin
                if ($urandom_range(0, 2) == 0) bin_a = corners[$urandom_range(0, 5)];
                else bin_a = 16'($urandom);
            end
            start_a = ($urandom_range(0, 31) == 0);
        end
        @(negedge clk);
        start_m = 1'b0;
        start_a = 1'b0;
        repeat (20) @(negedge clk);

        // Reset in the middle of a conversion.
        @(negedge clk);
        bin_m = 16'd777;
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (8) @(negedge clk);
        chk("midreset.was_busy", int'(busy_m), 1);
        @(posedge clk);
        #3 KEY = 1'b0;
        #1;
        check_all_zero("midreset");
        repeat (2) @(posedge clk);
        #3 KEY = 1'b1;
        cnt = 0;
        repeat (30) begin @(negedge clk); #1; if (done_m) cnt++; end
        chk("midreset.no_done", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
